// File: rtl/spi_mem_emu_param_if.sv
// -----------------------------------------------------------------------------
// spi_mem_emu_param_if
//   Request/response bundle between an SPI slave datapath (master side) and the
//   memory emulator (slave side).
//   Signals:
//     en       master->slave  request, held until valid seen
//     wr_en    master->slave  1 = write, 0 = read
//     addr     master->slave  word address (ADDR_W)
//     wr_data  master->slave  write data (DATA_W)
//     wr_mask  master->slave  per-bit write enable (DATA_W)
//     rd_data  slave->master  registered read result (DATA_W)
//     valid    slave->master  access complete
//     err      slave->master  out-of-range flag, qualified by valid
// -----------------------------------------------------------------------------
interface spi_mem_emu_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic              en;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] rd_data;
    logic              valid;
    logic              err;

    modport master (
        output en, wr_en, addr, wr_data, wr_mask,
        input  rd_data, valid, err
    );

    modport slave (
        input  en, wr_en, addr, wr_data, wr_mask,
        output rd_data, valid, err
    );
endinterface

// File: rtl/spi_mem_emu_param.sv
// -----------------------------------------------------------------------------
// spi_mem_emu_param
//   Register-file memory model behind an en/valid handshake. Each transaction
//   performs exactly one read or one bit-masked write at the access edge, then
//   asserts valid LATENCY cycles later and holds it until en is seen low.
//   Addresses >= DEPTH never touch the memory and read back as zero.
//
//   Optional feature macro: SPI_MEM_EMU_RANGE_ERR_EN
//     defined   : err rises together with valid for an out-of-range address
//     undefined : err is tied low
//
//   Ports:
//     clk_i   clock, rising edge
//     rst_i   synchronous reset, active high (memory contents are kept)
//     bus     spi_mem_emu_param_if.slave request/response bundle
// -----------------------------------------------------------------------------
module spi_mem_emu_param #(
    parameter int              DATA_W   = 8,
    parameter int              ADDR_W   = 6,
    parameter int              DEPTH    = 64,
    parameter int              LATENCY  = 7,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    spi_mem_emu_param_if.slave bus
);
    // Counter only ever holds LATENCY-1 down to 1.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              valid_q;
    logic [DATA_W-1:0] rd_data_q;

    // Power-up content only; reset never reloads it.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: INIT_VAL};

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              access;
    logic [DATA_W-1:0] mem_wdata_d;

    // The range test is also what keeps out-of-range writes off the array.
    assign in_range    = (32'(bus.addr) < DEPTH);
    assign idx         = IDX_W'(bus.addr);
    assign access      = (state_q == IDLE) && bus.en;
    assign mem_wdata_d = (mem_q[idx] & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);

    always_ff @(posedge clk_i) begin
        if (!rst_i && access && bus.wr_en && in_range) begin
            mem_q[idx] <= mem_wdata_d;
        end
    end

`ifdef SPI_MEM_EMU_RANGE_ERR_EN
    // Range result captured at the access edge; addr may wander during WAIT.
    logic oor_q;
    logic err_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            rd_data_q <= '0;
`ifdef SPI_MEM_EMU_RANGE_ERR_EN
            oor_q     <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.en) begin
                        if (!bus.wr_en) begin
                            rd_data_q <= in_range ? mem_q[idx] : '0;
                        end
                        cnt_q <= CNT_W'(LATENCY - 1);
`ifdef SPI_MEM_EMU_RANGE_ERR_EN
                        oor_q <= !in_range;
`endif
                        if (LATENCY == 1) begin
                            // Single-cycle latency skips WAIT entirely.
                            valid_q <= 1'b1;
`ifdef SPI_MEM_EMU_RANGE_ERR_EN
                            err_q   <= !in_range;
`endif
                            state_q <= DONE;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        valid_q <= 1'b1;
`ifdef SPI_MEM_EMU_RANGE_ERR_EN
                        err_q   <= oor_q;
`endif
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // An early en drop lands here too, giving a one-cycle pulse.
                    if (!bus.en) begin
                        valid_q <= 1'b0;
`ifdef SPI_MEM_EMU_RANGE_ERR_EN
                        err_q   <= 1'b0;
`endif
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.valid   = valid_q;
`ifdef SPI_MEM_EMU_RANGE_ERR_EN
    assign bus.err     = err_q;
`else
    assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_mem_emu_param.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_emu_param
//   Two instances: A with default parameters (8b, 64 words, latency 7) and
//   B with 16b data, 40 words, latency 1 and a non-zero INIT_VAL. A plain
//   array model of each memory predicts read data, latency and err.
// -----------------------------------------------------------------------------
module tb_spi_mem_emu_param;
    localparam int          LAT_A  = 7;
    localparam int          LAT_B  = 1;
    localparam int          DEP_A  = 64;
    localparam int          DEP_B  = 40;
    localparam logic [15:0] INIT_B = 16'h1234;
`ifdef SPI_MEM_EMU_RANGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_mem_emu_param_if #(.DATA_W(8),  .ADDR_W(6)) ifa ();
    spi_mem_emu_param_if #(.DATA_W(16), .ADDR_W(6)) ifb ();

    spi_mem_emu_param u_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifa)
    );

    spi_mem_emu_param #(
        .DATA_W   (16),
        .ADDR_W   (6),
        .DEPTH    (DEP_B),
        .LATENCY  (LAT_B),
        .INIT_VAL (INIT_B)
    ) u_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifb)
    );

    logic [15:0] mdl    [2][64];
    logic [15:0] rd_exp [2];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drv(input bit s, input bit e, input bit w, input logic [5:0] a,
                       input logic [15:0] d, input logic [15:0] m);
        if (s) begin
            ifb.en = e; ifb.wr_en = w; ifb.addr = a; ifb.wr_data = d; ifb.wr_mask = m;
        end else begin
            ifa.en = e; ifa.wr_en = w; ifa.addr = a; ifa.wr_data = d[7:0]; ifa.wr_mask = m[7:0];
        end
    endtask

    task automatic set_en(input bit s, input bit e);
        if (s) ifb.en = e;
        else   ifa.en = e;
    endtask

    function automatic logic [15:0] rd_o(input bit s);
        return s ? ifb.rd_data : {8'h00, ifa.rd_data};
    endfunction
    function automatic logic [15:0] vld_o(input bit s);
        return {15'd0, s ? ifb.valid : ifa.valid};
    endfunction
    function automatic logic [15:0] err_o(input bit s);
        return {15'd0, s ? ifb.err : ifa.err};
    endfunction

    // One transaction. hold = extra cycles en stays high after valid;
    // drop > 0 releases en at that negedge of the wait (protocol violation).
    task automatic xact(input bit s, input bit w, input int a, input logic [15:0] d,
                        input logic [15:0] m, input int hold, input int drop);
        int lat;
        bit seen;
        bit oor;
        int exp_lat;
        exp_lat = s ? LAT_B : LAT_A;
        oor     = a >= (s ? DEP_B : DEP_A);
        if (!s) begin
            d = d & 16'h00FF;
            m = m & 16'h00FF;
        end
        drv(s, 1'b1, w, 6'(a), d, m);
        @(posedge clk);
        if (w) begin
            if (!oor) mdl[s][a] = (mdl[s][a] & ~m) | (d & m);
        end else begin
            rd_exp[s] = oor ? 16'h0000 : mdl[s][a];
        end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (vld_o(s) == 16'd1) begin
                seen = 1'b1;
            end else begin
                // Anything on the bus during the wait must be ignored.
                drv(s, 1'b1, 1'($urandom), 6'($urandom), 16'($urandom), 16'($urandom));
                if (drop != 0 && lat >= drop) set_en(s, 1'b0);
            end
        end
        chk(seen ? "lat" : "lat_timeout", 16'(lat), 16'(exp_lat));
        chk("rd", rd_o(s), rd_exp[s]);
        chk("err", err_o(s), {15'd0, ERR_EN && oor});
        if (drop != 0) begin
            @(negedge clk);
            chk("pulse", vld_o(s), 16'd0);
        end else begin
            if (hold > 0) begin
                repeat (hold) @(negedge clk);
                chk("hold", vld_o(s), 16'd1);
            end
            set_en(s, 1'b0);
            @(negedge clk);
            chk("fall", vld_o(s), 16'd0);
            chk("errclr", err_o(s), 16'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mdl[0][i] = 16'h0000;
            mdl[1][i] = INIT_B;
        end
        rd_exp[0] = 16'h0000;
        rd_exp[1] = 16'h0000;
        drv(1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 16'h0);
        drv(1'b1, 1'b0, 1'b0, 6'd0, 16'h0, 16'h0);

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_vld", vld_o(1'(s)), 16'd0);
            chk("rst_rd",  rd_o(1'(s)),  16'd0);
            chk("rst_err", err_o(1'(s)), 16'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Basic write/read
        xact(1'b0, 1'b1, 5, 16'h00A5, 16'h00FF, 0, 0);
        xact(1'b0, 1'b0, 5, 16'h0, 16'h0, 0, 0);
        chk("t1_rd", rd_o(1'b0), 16'h00A5);

        // Bit mask
        xact(1'b0, 1'b1, 3, 16'h00FF, 16'h00FF, 0, 0);
        xact(1'b0, 1'b1, 3, 16'h0000, 16'h000F, 0, 0);
        xact(1'b0, 1'b0, 3, 16'h0, 16'h0, 0, 0);
        chk("t2_rd", rd_o(1'b0), 16'h00F0);

        // Long hold, then back-to-back access right after valid falls
        xact(1'b0, 1'b0, 5, 16'h0, 16'h0, 20, 0);
        xact(1'b0, 1'b0, 3, 16'h0, 16'h0, 0, 0);

        // Latency 1, 16-bit, range boundary
        xact(1'b1, 1'b1, 39, 16'hBEEF, 16'hFFFF, 0, 0);
        xact(1'b1, 1'b0, 39, 16'h0, 16'h0, 0, 0);
        chk("t4_rd39", rd_o(1'b1), 16'hBEEF);
        xact(1'b1, 1'b1, 40, 16'h1111, 16'hFFFF, 0, 0);
        xact(1'b1, 1'b0, 40, 16'h0, 16'h0, 0, 0);
        chk("t4_rd40", rd_o(1'b1), 16'h0000);
        xact(1'b1, 1'b0, 39, 16'h0, 16'h0, 0, 0);
        chk("t4_keep39", rd_o(1'b1), 16'hBEEF);
        xact(1'b1, 1'b0, 10, 16'h0, 16'h0, 0, 0);
        chk("t4_init", rd_o(1'b1), INIT_B);

        // Reset during WAIT after a write
        drv(1'b0, 1'b1, 1'b1, 6'd7, 16'h003C, 16'h00FF);
        @(posedge clk);
        mdl[0][7] = 16'h003C;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drv(1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        rd_exp[0] = 16'h0000;
        rd_exp[1] = 16'h0000;
        chk("t5_vld", vld_o(1'b0), 16'd0);
        chk("t5_rd",  rd_o(1'b0),  16'd0);
        repeat (10) @(negedge clk);
        chk("t5_idle", vld_o(1'b0), 16'd0);
        xact(1'b0, 1'b0, 7, 16'h0, 16'h0, 0, 0);
        chk("t5_rd7", rd_o(1'b0), 16'h003C);

        // Early en drop during WAIT
        xact(1'b0, 1'b1, 9, 16'h005A, 16'h00FF, 0, 3);
        xact(1'b0, 1'b0, 9, 16'h0, 16'h0, 0, 0);
        chk("t6_rd9", rd_o(1'b0), 16'h005A);

        // Random traffic on both instances
        for (int n = 0; n < 80; n++) begin
            bit s;
            int drop;
            s    = 1'($urandom_range(0, 1));
            drop = (!s && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0;
            xact(s, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), drop);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
